// File: rtl/audio_pkg.sv
// Shared constants and state encodings for the audio frame buffer.
// Optional drop counter is enabled with AUDIO_FRAME_DROP_CNT_EN.
package audio_pkg;

    localparam int SAMPLE_W          = 16;
    localparam int FRAME_LEN_DEFAULT = 256;

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILLING,
        B_FULL,
        B_READING
    } bank_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_STREAM
    } rd_state_e;

endpackage

// File: rtl/audio_frame_ram.sv
// Simple dual-port frame store: one write port, one read port with a
// registered read that holds its output while re is low.
module audio_frame_ram #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/audio_frame_buffer.sv
// Ping-pong frame buffer between the audio preprocessor and the analysis stage.
// Define AUDIO_FRAME_DROP_CNT_EN to add the saturating drop_count output.
module audio_frame_buffer #(
    parameter int FRAME_LEN = audio_pkg::FRAME_LEN_DEFAULT,
    parameter int SAMPLE_W  = audio_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] audio_sample,
    input  logic                sample_valid,
    output logic [SAMPLE_W-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic                overflow
`ifdef AUDIO_FRAME_DROP_CNT_EN
   ,output logic [15:0]         drop_count
`endif
);

    import audio_pkg::*;

    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam int ADDR_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    rd_state_e   rd_state_q, rd_state_d;

    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_wait_q, wr_wait_d;
    logic             last_full_q, last_full_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             m_valid_q, m_valid_d;
    logic             overflow_q, overflow_d;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [SAMPLE_W-1:0] ram_rdata;

    logic             release_bank;
    logic             other_free;
    logic             rd_sel;
    logic [IDX_W-1:0] rd_idx_nxt;

    assign rd_idx_nxt = rd_idx_q + IDX_W'(1);

    always_comb begin
        bank_d       = bank_q;
        rd_state_d   = rd_state_q;
        wr_bank_d    = wr_bank_q;
        wr_idx_d     = wr_idx_q;
        wr_wait_d    = wr_wait_q;
        last_full_d  = last_full_q;
        rd_bank_d    = rd_bank_q;
        rd_idx_d     = rd_idx_q;
        m_valid_d    = m_valid_q;
        overflow_d   = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = {wr_bank_q, wr_idx_q};
        ram_re       = 1'b0;
        ram_raddr    = {rd_bank_q, rd_idx_q};
        release_bank = 1'b0;
        other_free   = 1'b0;
        rd_sel       = 1'b0;

        // The RAM output register doubles as the prefetch stage: it only
        // advances on a handshake, so m_data holds while stalled.
        case (rd_state_q)
            R_IDLE: begin
                if (bank_q[0] == B_FULL || bank_q[1] == B_FULL) begin
                    if (bank_q[0] == B_FULL && bank_q[1] == B_FULL) begin
                        rd_sel = ~last_full_q;
                    end else begin
                        rd_sel = (bank_q[1] == B_FULL);
                    end
                    rd_bank_d      = rd_sel;
                    bank_d[rd_sel] = B_READING;
                    rd_state_d     = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_re     = 1'b1;
                ram_raddr  = {rd_bank_q, {IDX_W{1'b0}}};
                rd_idx_d   = '0;
                m_valid_d  = 1'b1;
                rd_state_d = R_STREAM;
            end
            R_STREAM: begin
                if (m_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        release_bank      = 1'b1;
                        bank_d[rd_bank_q] = B_EMPTY;
                        m_valid_d         = 1'b0;
                        if (bank_q[~rd_bank_q] == B_FULL) begin
                            rd_bank_d          = ~rd_bank_q;
                            bank_d[~rd_bank_q] = B_READING;
                            rd_state_d         = R_FETCH;
                        end else begin
                            rd_state_d = R_IDLE;
                        end
                    end else begin
                        ram_re    = 1'b1;
                        ram_raddr = {rd_bank_q, rd_idx_nxt};
                        rd_idx_d  = rd_idx_nxt;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        // A bank released this cycle counts as free, so a simultaneous
        // frame completion switches over without dropping.
        other_free = (bank_q[~wr_bank_q] == B_EMPTY) ||
                     (release_bank && (rd_bank_q == ~wr_bank_q));

        if (wr_wait_q) begin
            overflow_d = sample_valid;
            if (other_free) begin
                wr_wait_d = 1'b0;
                wr_bank_d = ~wr_bank_q;
            end
        end else if (sample_valid) begin
            ram_we = 1'b1;
            if (wr_idx_q == LAST_IDX) begin
                bank_d[wr_bank_q] = B_FULL;
                last_full_d       = wr_bank_q;
                wr_idx_d          = '0;
                if (other_free) begin
                    wr_bank_d = ~wr_bank_q;
                end else begin
                    wr_wait_d = 1'b1;
                end
            end else begin
                bank_d[wr_bank_q] = B_FILLING;
                wr_idx_d          = wr_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]   <= B_EMPTY;
            bank_q[1]   <= B_EMPTY;
            rd_state_q  <= R_IDLE;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            wr_wait_q   <= 1'b0;
            last_full_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            m_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            rd_state_q  <= rd_state_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            wr_wait_q   <= wr_wait_d;
            last_full_q <= last_full_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            m_valid_q   <= m_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    audio_frame_ram #(
        .DEPTH  (2 * FRAME_LEN),
        .DATA_W (SAMPLE_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (audio_sample),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign m_valid  = m_valid_q;
    assign m_data   = m_valid_q ? ram_rdata : '0;
    assign m_last   = m_valid_q && (rd_idx_q == LAST_IDX);
    assign overflow = overflow_q;

`ifdef AUDIO_FRAME_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (overflow_d && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer with FRAME_LEN=8; outputs sampled on negedge.
module tb_audio_frame_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] audio_sample = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        overflow;
`ifdef AUDIO_FRAME_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    audio_frame_buffer #(
        .FRAME_LEN (8),
        .SAMPLE_W  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .audio_sample (audio_sample),
        .sample_valid (sample_valid),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .overflow     (overflow)
`ifdef AUDIO_FRAME_DROP_CNT_EN
       ,.drop_count   (drop_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] v);
        sample_valid = 1'b1;
        audio_sample = v;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_i;
        int guard;

        // Reset values, reset asserted from time 0
        #2;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef AUDIO_FRAME_DROP_CNT_EN
        chk("rst_dropcnt", 32'(drop_count), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // One frame with m_ready held high
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) wr(16'(i));
        chk("t1_lat0", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t1_lat1", 32'(m_valid), 32'd0);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            chk("t1_valid", 32'(m_valid), 32'd1);
            chk("t1_data", 32'(m_data), 32'(k));
            chk("t1_last", 32'(m_last), 32'(k == 8));
            @(negedge clk);
        end
        chk("t1_end", 32'(m_valid), 32'd0);

        // Both banks filled with downstream stalled, then drops
        m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            wr(16'(16'h100 + i));
            chk("t2_noovf", 32'(overflow), 32'd0);
        end
        chk("t2_valid", 32'(m_valid), 32'd1);
        chk("t2_data", 32'(m_data), 32'h101);
        chk("t2_last", 32'(m_last), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wr(16'hDEAD);
            chk("t2_ovf", 32'(overflow), 32'd1);
        end
        @(negedge clk);
        chk("t2_ovf_end", 32'(overflow), 32'd0);
`ifdef AUDIO_FRAME_DROP_CNT_EN
        chk("t2_dropcnt", 32'(drop_count), 32'd4);
`endif

        // m_ready toggling while draining bank 1
        exp_i = 1;
        guard = 0;
        while (exp_i <= 8 && guard < 40) begin
            chk("t3_valid", 32'(m_valid), 32'd1);
            chk("t3_data", 32'(m_data), 32'(16'h100 + exp_i));
            chk("t3_last", 32'(m_last), 32'(exp_i == 8));
            m_ready = ((guard % 2) == 0);
            @(negedge clk);
            if (m_ready) exp_i++;
            guard++;
        end
        chk("t3_done", 32'(exp_i), 32'd9);
        chk("t3_fetch", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t3_next_valid", 32'(m_valid), 32'd1);
        chk("t3_next_data", 32'(m_data), 32'h109);

        // Last handshake of bank 0 coincides with completing bank 1
        m_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            wr(16'(16'h200 + j));
            if (j < 8) begin
                chk("t4_data", 32'(m_data), 32'(16'h109 + j));
                chk("t4_last", 32'(m_last), 32'(j == 7));
            end else begin
                chk("t4_idle", 32'(m_valid), 32'd0);
            end
        end
        wr(16'h301);
        chk("t4_noovf", 32'(overflow), 32'd0);
        chk("t4_fetch", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t4_valid", 32'(m_valid), 32'd1);
        chk("t4_data1", 32'(m_data), 32'h201);

        // Asynchronous reset while streaming
        rst = 1'b1;
        #1;
        chk("t5_arst_valid", 32'(m_valid), 32'd0);
        chk("t5_arst_data", 32'(m_data), 32'd0);
        chk("t5_arst_last", 32'(m_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset after a partial frame discards it
        for (int i = 1; i <= 5; i++) wr(16'(16'h400 + i));
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        chk("t5_rst_hold", 32'(m_valid), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) wr(16'(16'h500 + i));
        chk("t5_lat0", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t5_lat1", 32'(m_valid), 32'd0);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            chk("t5_valid", 32'(m_valid), 32'd1);
            chk("t5_data", 32'(m_data), 32'(16'h500 + k));
            chk("t5_last", 32'(m_last), 32'(k == 8));
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            chk("t5_no_old", 32'(m_valid), 32'd0);
            @(negedge clk);
        end

`ifdef AUDIO_FRAME_DROP_CNT_EN
        // Saturation of the drop counter
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b0;
        sample_valid = 1'b1;
        audio_sample = 16'h0BAD;
        repeat (16 + 70000) @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("t6_dropcnt_sat", 32'(drop_count), 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/audio_frame_buffer.md
AUDIO_FRAME_BUFFER -- requirements
Module: audio_frame_buffer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, samples per frame (power of two, 4..1024).
REQ-002 SHALL have parameter SAMPLE_W, default 16, sample width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port audio_sample  input  SAMPLE_W  DC-removed sample from the preprocessor stage.
REQ-006 SHALL have port sample_valid  input  1  one-cycle strobe qualifying audio_sample.
REQ-007 SHALL have port m_data  output  SAMPLE_W  frame sample toward the downstream analysis stage.
REQ-008 SHALL have port m_valid  output  1  m_data valid.
REQ-009 SHALL have port m_ready  input  1  downstream accepts m_data.
REQ-010 SHALL have port m_last  output  1  marks the final sample of a frame, qualified by m_valid.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse per dropped input sample.

Function
REQ-012 SHALL hold two banks of FRAME_LEN x SAMPLE_W words (ping-pong); each bank is EMPTY, FILLING, FULL or READING.
REQ-013 SHALL write each sample_valid sample into the FILLING bank at wr_idx, then increment wr_idx; writing at FRAME_LEN-1 marks the bank FULL and clears wr_idx to 0.
REQ-014 SHALL switch the writer to the other bank in the cycle after a frame completes, if that bank is EMPTY; otherwise the writer enters WAIT.
REQ-015 In WAIT, each sample_valid sample SHALL be dropped and overflow SHALL pulse for one cycle; the writer SHALL leave WAIT on the cycle the other bank becomes EMPTY.
REQ-016 If a bank release and a frame completion occur in the same cycle, the writer SHALL take the freed bank with no drop.
REQ-017 The reader FSM SHALL use the states R_IDLE, R_FETCH and R_STREAM; R_IDLE goes to R_FETCH when any bank is FULL, oldest frame first.
REQ-018 R_FETCH SHALL issue a 1-cycle-latency RAM read for index 0; m_valid SHALL rise 2 cycles after the bank becomes FULL.
REQ-019 SHALL follow valid/ready rules: once m_valid is high, m_data, m_last and m_valid stay stable until m_ready is high.
REQ-020 SHALL stream one word per cycle while m_ready is held high, using a prefetch register (skid) so there are no bubbles.
REQ-021 m_last SHALL be high exactly with index FRAME_LEN-1; on that handshake the bank becomes EMPTY.
REQ-022 After the handshake in REQ-021, the reader SHALL go to R_FETCH if the other bank is FULL, else to R_IDLE.
REQ-023 Frame samples SHALL be output in write order without modification; no partial frame is ever output.

Reset
REQ-024 On rst high, immediately and asynchronously: both banks EMPTY, writer on bank 0 with wr_idx=0, reader R_IDLE.
REQ-025 On rst high, m_valid=0, m_last=0, m_data=0 and overflow=0.
REQ-026 A reset mid-frame SHALL discard partial and unread frames; RAM contents need not be cleared.

Configuration
REQ-027 With AUDIO_FRAME_DROP_CNT_EN defined, SHALL add output drop_count (16 bits): increments on each overflow pulse, saturates at 16'hFFFF, resets to 0.
REQ-028 Without AUDIO_FRAME_DROP_CNT_EN, the drop_count port and its logic SHALL be absent; overflow is unchanged.

Structure
REQ-029 Package audio_pkg SHALL hold SAMPLE_W, the default FRAME_LEN, the bank-state enum and the reader-state enum.
REQ-030 Storage SHALL be sub-module audio_frame_ram: simple dual-port, 1 write port and 1 read port, 1-cycle registered read, depth 2*FRAME_LEN, address {bank, idx}.

Verification (FRAME_LEN=8)
REQ-031 Write 8 samples 0x0001..0x0008 with m_ready=1 -> m_valid rises 2 cycles after the 8th strobe; 0x0001..0x0008 out on consecutive cycles; m_last only with 0x0008.
REQ-032 Write 16 samples back-to-back with m_ready=0 -> both banks FULL, then 4 more strobes give 4 overflow pulses (drop_count=4 when enabled).
REQ-033 Toggle m_ready 1/0 every cycle during a frame -> no sample lost or duplicated; m_data stable while stalled.
REQ-034 Last handshake of bank 0 in the same cycle the 8th sample of bank 1 is written -> writer takes bank 0; the next strobe gives no overflow.
REQ-035 Assert rst after 5 of 8 samples, then write 8 new samples -> only the new frame appears; m_valid=0 during reset.
REQ-036 With AUDIO_FRAME_DROP_CNT_EN, force 70000 drops -> drop_count holds 16'hFFFF.
